// File: rtl/rect_load_demux_if.sv
// Bus between the rect descriptor loader and its environment: start/busy/done
// handshake, memory read port and the rect parameter write port.
interface rect_load_demux_if #(
   parameter int unsigned RECT_COUNT  = 4,
   parameter int unsigned FIELD_WIDTH = 3
);
   logic                   start;
   logic                   busy;
   logic                   done;
   logic                   mem_rd;
   logic [15:0]            mem_addr;
   logic [15:0]            mem_data;
   logic [RECT_COUNT-1:0]  wr_en;
   logic [FIELD_WIDTH-1:0] wr_field;
   logic [15:0]            wr_data;

   modport master (
      input  start, mem_data,
      output busy, done, mem_rd, mem_addr, wr_en, wr_field, wr_data
   );

   modport slave (
      output start, mem_data,
      input  busy, done, mem_rd, mem_addr, wr_en, wr_field, wr_data
   );
endinterface

// File: rtl/rect_load_demux.sv
// Per-frame loader of rect descriptors into the rect parameter bank via a one-hot index demux.
// Define RECT_LOAD_DEMUX_PIPE_EN to build the demux as one registered tree level per index bit.
module rect_load_demux #(
   parameter int unsigned RECT_COUNT       = 4,
   parameter int unsigned RECT_COUNT_WIDTH = 2,
   parameter int unsigned WORDS_PER_RECT   = 6,
   parameter int unsigned FIELD_WIDTH      = 3,
   parameter logic [15:0] BASE_ADDR        = 16'h0000
) (
   input logic              clk,
   input logic              reset,
   rect_load_demux_if.master bus
);
   localparam int unsigned RW = RECT_COUNT_WIDTH;
   localparam int unsigned FW = FIELD_WIDTH;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t         state, state_nxt;
   logic [RW-1:0]  rect_idx, rect_nxt;
   logic [FW-1:0]  field_idx, field_nxt;
   logic           mem_rd_nxt, busy_nxt;
   logic [15:0]    addr_nxt;
   logic           last_rd_c;

   assign last_rd_c = (rect_idx == RW'(RECT_COUNT - 1)) && (field_idx == FW'(WORDS_PER_RECT - 1));

   // Read sequencer state and registered read-port outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         rect_idx     <= '0;
         field_idx    <= '0;
         bus.mem_rd   <= 1'b0;
         bus.mem_addr <= '0;
         bus.busy     <= 1'b0;
      end else begin
         state        <= state_nxt;
         rect_idx     <= rect_nxt;
         field_idx    <= field_nxt;
         bus.mem_rd   <= mem_rd_nxt;
         bus.mem_addr <= addr_nxt;
         bus.busy     <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      rect_nxt   = rect_idx;
      field_nxt  = field_idx;
      mem_rd_nxt = 1'b0;
      addr_nxt   = bus.mem_addr;
      busy_nxt   = bus.busy;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt  = READ;
               rect_nxt   = '0;
               field_nxt  = '0;
               mem_rd_nxt = 1'b1;
               addr_nxt   = BASE_ADDR;
               busy_nxt   = 1'b1;
            end
         end
         READ: begin
            if (last_rd_c) begin
               state_nxt = DRAIN;
            end else begin
               mem_rd_nxt = 1'b1;
               addr_nxt   = bus.mem_addr + 16'd1;
               if (field_idx == FW'(WORDS_PER_RECT - 1)) begin
                  field_nxt = '0;
                  rect_nxt  = rect_idx + RW'(1);
               end else begin
                  field_nxt = field_idx + FW'(1);
               end
            end
         end
         DRAIN: begin
            // A start coincident with done chains straight into the next load
            if (bus.done) begin
               if (bus.start) begin
                  state_nxt  = READ;
                  rect_nxt   = '0;
                  field_nxt  = '0;
                  mem_rd_nxt = 1'b1;
                  addr_nxt   = BASE_ADDR;
               end else begin
                  state_nxt = IDLE;
                  busy_nxt  = 1'b0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Index tag of the read in flight, aligned with mem_data
   logic          s1_valid, s1_last;
   logic [RW-1:0] s1_rect;
   logic [FW-1:0] s1_field;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_rect  <= '0;
         s1_field <= '0;
      end else begin
         s1_valid <= bus.mem_rd;
         s1_last  <= bus.mem_rd && last_rd_c;
         s1_rect  <= rect_idx;
         s1_field <= field_idx;
      end
   end

`ifdef RECT_LOAD_DEMUX_PIPE_EN
   localparam int unsigned LV = RECT_COUNT_WIDTH;

   logic [RECT_COUNT-1:0] in_oh    [LV];
   logic [RECT_COUNT-1:0] nx_oh    [LV];
   logic [RW-1:0]         in_rect  [LV];
   logic [FW-1:0]         in_field [LV];
   logic [15:0]           in_data  [LV];
   logic                  in_last  [LV];
   logic [RECT_COUNT-1:0] lv_oh    [LV];
   logic [RW-1:0]         lv_rect  [LV];
   logic [FW-1:0]         lv_field [LV];
   logic [15:0]           lv_data  [LV];
   logic                  lv_last  [LV];

   // Level k splits index bit RW-1-k, doubling the number of one-hot groups
   always_comb begin
      in_oh    = '{default: '0};
      nx_oh    = '{default: '0};
      in_rect  = '{default: '0};
      in_field = '{default: '0};
      in_data  = '{default: '0};
      in_last  = '{default: 1'b0};
      in_oh[0]    = RECT_COUNT'(s1_valid);
      in_rect[0]  = s1_rect;
      in_field[0] = s1_field;
      in_data[0]  = bus.mem_data;
      in_last[0]  = s1_last;
      for (int k = 1; k < LV; k++) begin
         in_oh[k]    = lv_oh[k-1];
         in_rect[k]  = lv_rect[k-1];
         in_field[k] = lv_field[k-1];
         in_data[k]  = lv_data[k-1];
         in_last[k]  = lv_last[k-1];
      end
      for (int k = 0; k < LV; k++) begin
         for (int j = 0; j < RECT_COUNT; j++) begin
            if (j < (2 << k))
               nx_oh[k][j] = in_oh[k][j >> 1] & (in_rect[k][RW-1-k] == j[0]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < LV; k++) begin
            lv_oh[k]    <= '0;
            lv_rect[k]  <= '0;
            lv_field[k] <= '0;
            lv_data[k]  <= '0;
            lv_last[k]  <= 1'b0;
         end
      end else begin
         for (int k = 0; k < LV; k++) begin
            lv_oh[k]    <= nx_oh[k];
            lv_rect[k]  <= in_rect[k];
            lv_field[k] <= (|in_oh[k]) ? in_field[k] : '0;
            lv_data[k]  <= (|in_oh[k]) ? in_data[k] : '0;
            lv_last[k]  <= in_last[k];
         end
      end
   end

   assign bus.wr_en    = lv_oh[LV-1];
   assign bus.wr_field = lv_field[LV-1];
   assign bus.wr_data  = lv_data[LV-1];
   assign bus.done     = lv_last[LV-1];
`else
   // Single decode of the tagged rect index into the write strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.wr_en    <= '0;
         bus.wr_field <= '0;
         bus.wr_data  <= '0;
         bus.done     <= 1'b0;
      end else begin
         bus.wr_en    <= s1_valid ? (RECT_COUNT'(1) << s1_rect) : '0;
         bus.wr_field <= s1_valid ? s1_field : '0;
         bus.wr_data  <= s1_valid ? bus.mem_data : '0;
         bus.done     <= s1_last;
      end
   end
`endif
endmodule
